// File: rtl/eth_rgmii_pkg.sv
// eth_rgmii_pkg: RGMII receive speed codes, nibble-FSM encodings and beat type.
`default_nettype none

package eth_rgmii_pkg;

  localparam logic [1:0] SPEED_10   = 2'b00;
  localparam logic [1:0] SPEED_100  = 2'b01;
  localparam logic [1:0] SPEED_1000 = 2'b10;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_NIB_LO = 2'd1;
  localparam logic [1:0] ST_NIB_HI = 2'd2;

  typedef struct packed {
    logic [7:0] rxd;
    logic       dv;
    logic       er;
  } gmii_beat_t;

  // The reserved code 2'b11 is decoded as gigabit.
  function automatic logic is_gig(input logic [1:0] spd);
    return (spd == SPEED_1000) || (spd == 2'b11);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rgmii_nibble_pack.sv
// rgmii_nibble_pack: assembles 10/100 RGMII nibbles (low first) into bytes with a sticky error flag.
`default_nettype none

module rgmii_nibble_pack
  import eth_rgmii_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       dv_i,
  input  logic       er_i,
  input  logic       arm_i,
  input  logic [3:0] nib_i,
  output logic [1:0] state_o,
  output logic       byte_vld_o,
  output logic [7:0] byte_o,
  output logic       byte_er_o,
  output logic       odd_o
);

  logic [1:0] state_q, state_d;
  logic [3:0] lo_q, lo_d;
  logic       err_q, err_d;

  always_comb begin
    state_d    = state_q;
    lo_d       = lo_q;
    err_d      = err_q;
    byte_vld_o = 1'b0;
    byte_o     = {nib_i, lo_q};
    byte_er_o  = err_q | er_i;
    odd_o      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // arm_i is low only while a frame caught mid-way by reset is still running.
        if (dv_i && arm_i) begin
          state_d = ST_NIB_LO;
          lo_d    = nib_i;
          err_d   = er_i;
        end
      end
      ST_NIB_LO: begin
        if (dv_i) begin
          state_d    = ST_NIB_HI;
          byte_vld_o = 1'b1;
        end else begin
          state_d = ST_IDLE;
          odd_o   = 1'b1;
        end
      end
      ST_NIB_HI: begin
        if (dv_i) begin
          state_d = ST_NIB_LO;
          lo_d    = nib_i;
          err_d   = er_i;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lo_q    <= 4'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
    end
  end

  assign state_o = state_q;

endmodule

`default_nettype wire

// File: rtl/rgmii_rx_decode.sv
// rgmii_rx_decode: RGMII DDR-sample decoder to GMII beats for 1000/100/10 links.
// Define RGMII_RX_INBAND_STATUS_EN to add the in-band link_status output.
`default_nettype none

module rgmii_rx_decode
  import eth_rgmii_pkg::*;
#(
  parameter logic [1:0] GMII_SPEED_DEFAULT = 2'b10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] q1,
  input  logic [4:0] q2,
  input  logic [1:0] speed,
  output logic [7:0] gmii_rxd,
  output logic       gmii_rx_dv,
  output logic       gmii_rx_er,
  output logic       gmii_valid,
  output logic       odd_nibble
`ifdef RGMII_RX_INBAND_STATUS_EN
  ,
  output logic [3:0] link_status
`endif
);

  logic       w_dv, w_er, w_gig;
  logic [1:0] w_state;
  logic       w_byte_vld, w_byte_er, w_odd;
  logic [7:0] w_byte;

  gmii_beat_t beat_q, beat_d;
  logic       valid_q, valid_d;
  logic       odd_q, odd_d;
  logic [1:0] speed_q, speed_d;
  logic       armed_q, armed_d;

  assign w_dv  = q1[4];
  assign w_er  = q1[4] ^ q2[4];
  assign w_gig = is_gig(speed_q);

  rgmii_nibble_pack u_nibble_pack (
    .clk       (clk),
    .rst_n     (rst_n),
    .dv_i      (w_dv),
    .er_i      (w_er),
    .arm_i     (armed_q),
    .nib_i     (q1[3:0]),
    .state_o   (w_state),
    .byte_vld_o(w_byte_vld),
    .byte_o    (w_byte),
    .byte_er_o (w_byte_er),
    .odd_o     (w_odd)
  );

  always_comb begin
    beat_d  = beat_q;
    valid_d = 1'b0;
    odd_d   = 1'b0;
    speed_d = speed_q;
    armed_d = armed_q | ~w_dv;
    // Speed only changes between frames so a frame never mixes decode modes.
    if (w_state == ST_IDLE && !w_dv) begin
      speed_d = speed;
    end
    if (w_gig) begin
      if (armed_q) begin
        beat_d.rxd = {q2[3:0], q1[3:0]};
        beat_d.dv  = w_dv;
        beat_d.er  = w_er;
        valid_d    = 1'b1;
      end
    end else begin
      if (w_byte_vld) begin
        beat_d.rxd = w_byte;
        beat_d.dv  = 1'b1;
        beat_d.er  = w_byte_er;
        valid_d    = 1'b1;
      end
      odd_d = w_odd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_q  <= '0;
      valid_q <= 1'b0;
      odd_q   <= 1'b0;
      speed_q <= GMII_SPEED_DEFAULT;
      armed_q <= 1'b0;
    end else begin
      beat_q  <= beat_d;
      valid_q <= valid_d;
      odd_q   <= odd_d;
      speed_q <= speed_d;
      armed_q <= armed_d;
    end
  end

  assign gmii_rxd   = beat_q.rxd;
  assign gmii_rx_dv = beat_q.dv;
  assign gmii_rx_er = beat_q.er;
  assign gmii_valid = valid_q;
  assign odd_nibble = odd_q;

`ifdef RGMII_RX_INBAND_STATUS_EN
  logic [3:0] link_q;

  // Idle inter-frame samples carry {duplex, speed, link} on rxd.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      link_q <= 4'h0;
    end else if (!q1[4] && !q2[4]) begin
      link_q <= q1[3:0];
    end
  end

  assign link_status = link_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rgmii_rx_decode.sv
// tb_rgmii_rx_decode: directed stimulus with a queue scoreboard checked by an independent monitor.
`default_nettype none

module tb_rgmii_rx_decode;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] q1 = 5'h00;
  logic [4:0] q2 = 5'h00;
  logic [1:0] speed = 2'b10;
  logic [7:0] gmii_rxd;
  logic       gmii_rx_dv, gmii_rx_er, gmii_valid, odd_nibble;
`ifdef RGMII_RX_INBAND_STATUS_EN
  logic [3:0] link_status;
`endif

  rgmii_rx_decode #(.GMII_SPEED_DEFAULT(2'b10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .q1         (q1),
    .q2         (q2),
    .speed      (speed),
    .gmii_rxd   (gmii_rxd),
    .gmii_rx_dv (gmii_rx_dv),
    .gmii_rx_er (gmii_rx_er),
    .gmii_valid (gmii_valid),
    .odd_nibble (odd_nibble)
`ifdef RGMII_RX_INBAND_STATUS_EN
    ,
    .link_status(link_status)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] rxd;
    logic       dv;
    logic       er;
    int         due;
  } exp_t;

  exp_t bq[$];
  int   oq[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drv(input logic [4:0] a, input logic [4:0] b);
    q1 = a;
    q2 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic exp_beat(input logic [7:0] d, input logic v, input logic e);
    exp_t x;
    x.rxd = d;
    x.dv  = v;
    x.er  = e;
    x.due = cyc + 1;
    bq.push_back(x);
  endtask

  // Monitor: every presented beat or odd pulse must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n && gmii_valid) begin
      tests++;
      if (bq.size() == 0) begin
        fails++;
        $display("FAIL beat: unexpected beat rxd=%0h dv=%0b er=%0b at cycle %0d",
                 gmii_rxd, gmii_rx_dv, gmii_rx_er, cyc);
      end else begin
        exp_t e;
        e = bq.pop_front();
        if (gmii_rxd !== e.rxd || gmii_rx_dv !== e.dv || gmii_rx_er !== e.er || cyc != e.due) begin
          fails++;
          $display("FAIL beat: got rxd=%0h dv=%0b er=%0b cyc=%0d expected rxd=%0h dv=%0b er=%0b cyc=%0d",
                   gmii_rxd, gmii_rx_dv, gmii_rx_er, cyc, e.rxd, e.dv, e.er, e.due);
        end
      end
    end
    if (rst_n && odd_nibble) begin
      tests++;
      if (oq.size() == 0) begin
        fails++;
        $display("FAIL odd_nibble: unexpected pulse at cycle %0d", cyc);
      end else begin
        int d;
        d = oq.pop_front();
        if (cyc != d) begin
          fails++;
          $display("FAIL odd_nibble: pulse at cycle %0d expected cycle %0d", cyc, d);
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rxd"}, {24'h0, gmii_rxd}, 32'h0);
    chk({tag, "_dv"}, {31'h0, gmii_rx_dv}, 32'h0);
    chk({tag, "_er"}, {31'h0, gmii_rx_er}, 32'h0);
    chk({tag, "_valid"}, {31'h0, gmii_valid}, 32'h0);
    chk({tag, "_odd"}, {31'h0, odd_nibble}, 32'h0);
`ifdef RGMII_RX_INBAND_STATUS_EN
    chk({tag, "_link"}, {28'h0, link_status}, 32'h0);
`endif
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");

    // Gigabit idle after reset: first cycle arms, then a beat every cycle.
    rst_n = 1'b1;
    drv(5'h00, 5'h00);
    exp_beat(8'h00, 1'b0, 1'b0); drv(5'h00, 5'h00);

    // Gigabit frame A5 x3.
    repeat (3) begin
      exp_beat(8'hA5, 1'b1, 1'b0); drv(5'h15, 5'h1A);
    end
    exp_beat(8'h00, 1'b0, 1'b0); drv(5'h00, 5'h00);

    // Gigabit error on middle byte, then carrier extension.
    exp_beat(8'hA5, 1'b1, 1'b0); drv(5'h15, 5'h1A);
    exp_beat(8'hC3, 1'b1, 1'b1); drv(5'h13, 5'h0C);
    exp_beat(8'hA5, 1'b1, 1'b0); drv(5'h15, 5'h1A);
    exp_beat(8'hFF, 1'b0, 1'b1); drv(5'h0F, 5'h1F);
    exp_beat(8'h00, 1'b0, 1'b0); drv(5'h00, 5'h00);
    exp_beat(8'h00, 1'b0, 1'b0); drv(5'h00, 5'h00);

    // Speed changed mid-frame: frame and following idle cycle stay gigabit.
    exp_beat(8'hA5, 1'b1, 1'b0); drv(5'h15, 5'h1A);
    speed = 2'b01;
    exp_beat(8'hA5, 1'b1, 1'b0); drv(5'h15, 5'h1A);
    exp_beat(8'hA5, 1'b1, 1'b0); drv(5'h15, 5'h1A);
    exp_beat(8'h00, 1'b0, 1'b0); drv(5'h00, 5'h00);
    exp_beat(8'h00, 1'b0, 1'b0); drv(5'h00, 5'h00);
    drv(5'h00, 5'h00);
    drv(5'h00, 5'h00);

    // 100M nibbles 5,A,3,C.
    drv(5'h15, 5'h1F);
    exp_beat(8'hA5, 1'b1, 1'b0); drv(5'h1A, 5'h1F);
    drv(5'h13, 5'h1F);
    exp_beat(8'hC3, 1'b1, 1'b0); drv(5'h1C, 5'h1F);
    drv(5'h00, 5'h00);
    drv(5'h00, 5'h00);

    // 100M three nibbles with error on the low nibble, then odd end and ignored extension.
    drv(5'h15, 5'h05);
    exp_beat(8'hA5, 1'b1, 1'b1); drv(5'h1A, 5'h1F);
    drv(5'h13, 5'h1F);
    oq.push_back(cyc + 1); drv(5'h00, 5'h00);
    drv(5'h0F, 5'h1F);
    drv(5'h00, 5'h00);
    drv(5'h00, 5'h00);

    // Reset mid-frame: outputs clear at once, running frame is ignored.
    drv(5'h15, 5'h1F);
    q1 = 5'h1A;
    q2 = 5'h1F;
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    drv(5'h1A, 5'h1F);
    drv(5'h1A, 5'h1F);
    drv(5'h1A, 5'h1F);
    drv(5'h00, 5'h00);
    drv(5'h00, 5'h00);
    drv(5'h15, 5'h1F);
    exp_beat(8'hA5, 1'b1, 1'b0); drv(5'h1A, 5'h1F);
    drv(5'h00, 5'h00);
    drv(5'h00, 5'h00);

`ifdef RGMII_RX_INBAND_STATUS_EN
    drv(5'h0D, 5'h0D);
    chk("link_latch", {28'h0, link_status}, 32'hD);
    drv(5'h03, 5'h1F);
    chk("link_hold", {28'h0, link_status}, 32'hD);
`endif

    drv(5'h00, 5'h00);
    drv(5'h00, 5'h00);
    drv(5'h00, 5'h00);
    chk("beats_left", bq.size(), 32'h0);
    chk("odd_left", oq.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rgmii_rx_decode.md
RGMII_RX_DECODE -- requirements
Module: rgmii_rx_decode

Interface
REQ-001 SHALL have parameter GMII_SPEED_DEFAULT, default 2'b10, the speed code in use when no speed is latched.
REQ-002 SHALL have port clk, input, 1: RX clock shared with the upstream input DDR stage.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port q1, input, 5: rising-edge sample {rx_ctl, rxd[3:0]} from the input DDR stage.
REQ-005 SHALL have port q2, input, 5: falling-edge sample {rx_ctl, rxd[3:0]} from the input DDR stage.
REQ-006 SHALL have port speed, input, 2: link speed (10 = 1000M, 01 = 100M, 00 = 10M, 11 treated as 1000M).
REQ-007 SHALL have port gmii_rxd, output, 8: received byte.
REQ-008 SHALL have port gmii_rx_dv, output, 1: byte valid inside frame.
REQ-009 SHALL have port gmii_rx_er, output, 1: receive error qualifier.
REQ-010 SHALL have port gmii_valid, output, 1: strobe marking a new gmii_* beat.
REQ-011 SHALL have port odd_nibble, output, 1: one-cycle pulse when a 10/100 frame ends on an unpaired nibble.
REQ-012 SHALL have port link_status, output, 4: in-band {duplex, speed[1:0], link}; exists only with the macro.

Function
REQ-013 SHALL decode per cycle: dv = q1[4]; er = q1[4] XOR q2[4].
REQ-014 SHALL, in 1000 mode, output gmii_rxd = {q2[3:0], q1[3:0]}, gmii_rx_dv = dv, gmii_rx_er = er, gmii_valid = 1, all registered with 1-cycle latency.
REQ-015 SHALL, in 10/100 mode, use q1[3:0] as the nibble and ignore q2 data bits.
REQ-016 SHALL, in 10/100 mode, run an FSM with states IDLE, NIB_LO and NIB_HI:
  - IDLE -> NIB_LO when dv rises, capturing that nibble as the low nibble.
  - NIB_LO -> NIB_HI on the next dv cycle; the byte is emitted here, with gmii_valid high 1 cycle after the high nibble.
  - NIB_HI -> NIB_LO on the next dv cycle.
  - Any state -> IDLE when dv = 0.
REQ-017 SHALL emit the byte as low nibble first: gmii_rxd = {hi, lo}.
REQ-018 SHALL OR er into a sticky per-byte flag and present it on gmii_rx_er with that byte.
REQ-019 SHALL, when dv falls in NIB_LO (odd nibble count), discard the nibble and pulse odd_nibble for 1 cycle, with no gmii_valid.
REQ-020 SHALL, in 10/100 mode, drive gmii_valid low on non-emit cycles, with gmii_rxd/gmii_rx_dv/gmii_rx_er holding their last values.
REQ-021 SHALL sample speed only in IDLE with dv = 0; a change mid-frame takes effect after the frame ends.
REQ-022 SHALL emit a carrier-extension/error beat (dv = 0, er = 1) with gmii_rx_dv = 0, gmii_rx_er = 1 and gmii_valid = 1 in 1000 mode, and ignore it in 10/100 mode.

Reset
REQ-023 SHALL, on rst_n low, asynchronously clear gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_valid, odd_nibble and link_status to 0, set the FSM to IDLE, and set the latched speed to GMII_SPEED_DEFAULT.
REQ-024 SHALL, when reset asserts mid-frame, drop the partial byte; after deassertion, decoding resumes at the next dv rising edge only, and a frame already in progress is ignored until dv = 0.

Configuration
REQ-025 SHALL, when RGMII_RX_INBAND_STATUS_EN is defined, latch link_status = q1[3:0] on every cycle where q1[4] = 0 and q2[4] = 0, holding it otherwise.
REQ-026 SHALL, when RGMII_RX_INBAND_STATUS_EN is undefined, omit the link_status port and its register.

Structure
REQ-027 SHALL place speed code constants (SPEED_10/100/1000) and FSM state encodings in shared package eth_rgmii_pkg.
REQ-028 SHALL implement the 10/100 nibble assembler as sub-module rgmii_nibble_pack, instantiated once.

Verification
REQ-029 SHALL cover 1000 mode, q1 = 5'h15 and q2 = 5'h1A for 3 cycles -> gmii_rxd = 8'hA5, dv = 1, er = 0, valid each cycle, 1-cycle latency.
REQ-030 SHALL cover 100 mode, nibbles 5, A, 3, C with dv = 1 -> bytes 8'hA5 then 8'hC3, each valid 1 cycle after its high nibble, valid low between.
REQ-031 SHALL cover 100 mode, 3 nibbles then dv = 0 -> one byte, then an odd_nibble pulse and no second valid.
REQ-032 SHALL cover 1000 mode, q1[4] = 1 and q2[4] = 0 on one byte -> that byte has er = 1, and neighbouring bytes have er = 0.
REQ-033 SHALL cover speed switched 10 -> 01 mid-frame -> the frame finishes in 1000 mode and the next frame decodes as nibbles.
REQ-034 SHALL cover, with the macro, idle q1 = q2 = 5'h0D -> link_status = 4'hD; and cover rst_n pulsed mid-frame -> all outputs 0 immediately, with no beats until the next dv rise.
